// File: rtl/gencon_pkg.sv
// Shared types and constants for the gen_con keypad calculator core.
// Holds the FSM state encoding, operator codes and sign-magnitude helpers.
package gencon_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    COMPUTE = 2'b01,
    DONE    = 2'b10,
    ENTER_B = 2'b11
  } state_e;

  localparam logic [2:0]  OP_NEG     = 3'b001;
  localparam logic [2:0]  OP_ADD     = 3'b010;
  localparam logic [2:0]  OP_SUB     = 3'b011;
  localparam logic [2:0]  OP_MUL     = 3'b100;
  localparam logic [14:0] MAX_MAG    = 15'd32767;
  localparam logic [3:0]  MULT_STEPS = 4'd15;

  // A zero magnitude never shows a sign, so -0 and +0 display identically.
  function automatic logic [15:0] to_sm(input logic sign, input logic [14:0] mag);
    return {sign & (mag != 15'd0), mag};
  endfunction

  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/gen_con_mult.sv
// Sequential 15x15 unsigned shift-add multiplier: one load cycle on start,
// then MULT_STEPS shift steps; done is high during the final step.
module gen_con_mult
  import gencon_pkg::*;
(
  input  logic        clk,
  input  logic        nRST,
  input  logic        start,
  input  logic [14:0] a,
  input  logic [14:0] b,
  output logic        busy,
  output logic        done,
  output logic [29:0] product
);

  logic [29:0] acc_q;
  logic [29:0] mcand_q;
  logic [14:0] mplier_q;
  logic [3:0]  cnt_q;
  logic        busy_q;

  always_ff @(posedge clk or negedge nRST) begin
    // NOTE: datapath registers are reset too, so an aborted multiply leaves no stale partial product.
    if (!nRST) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {15'd0, a};
      mplier_q <= b;
      cnt_q    <= MULT_STEPS;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) busy_q <= 1'b0;
    end
  end

  // Signalled during the last step so the caller can move on at the same edge
  // the final partial sum lands; product is valid from the following cycle.
  assign done    = busy_q && (cnt_q == 4'd1);
  assign busy    = busy_q;
  assign product = acc_q;

endmodule

// File: rtl/gen_con.sv
// Control and datapath core of the 16-bit signed keypad calculator.
// Define GENCON_SATURATE_EN to clamp oversized results to 32767 instead of wrapping.
module gen_con
  import gencon_pkg::*;
(
  input  logic        clk,
  input  logic        nRST,
  input  logic [3:0]  keypad_input,
  input  logic        read_input,
  input  logic [2:0]  operator_input,
  input  logic        equal_input,
  output logic        complete,
  output logic [15:0] display_output,
  output logic        key_read
);

  state_e      current_state, next_state;
  logic        read_prev_q, equal_prev_q;
  logic [2:0]  op_prev_q;
  logic [14:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [2:0]  opcode_q, opcode_d;
  logic [15:0] display_q, display_d;
  logic        complete_q, complete_d;
  logic        key_read_q, key_read_d;

  logic        digit_evt, op_evt, eq_evt;
  logic        is_b, act_sign, digit_ok;
  logic [14:0] act_mag;
  logic [18:0] digit_acc;

  logic        mult_start, mult_busy, mult_done;
  logic [29:0] mult_product;

  logic [16:0] a_tc, b_tc, sum_tc, sum_abs;
  logic [29:0] res_wide;
  logic [14:0] res_mag;
  logic        res_sign;
  logic [15:0] result_sm;

  assign digit_evt = read_input & ~read_prev_q;
  assign op_evt    = (op_prev_q == 3'b000) && (operator_input != 3'b000);
  assign eq_evt    = equal_input & ~equal_prev_q;

  assign is_b      = (current_state == ENTER_B);
  assign act_mag   = is_b ? mag_b_q : mag_a_q;
  assign act_sign  = is_b ? sign_b_q : sign_a_q;
  assign digit_acc = ({4'd0, act_mag} * 19'd10) + {15'd0, keypad_input};
  assign digit_ok  = (keypad_input <= 4'd9) && (digit_acc <= {4'd0, MAX_MAG});

  assign mult_start = (current_state == COMPUTE) && (opcode_q == OP_MUL) && !mult_busy;

  gen_con_mult u_mult (
    .clk     (clk),
    .nRST    (nRST),
    .start   (mult_start),
    .a       (mag_a_q),
    .b       (mag_b_q),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (mult_product)
  );

  // Operands are stable through COMPUTE and DONE, so the result is purely combinational.
  always_comb begin
    a_tc    = sign_a_q ? (17'd0 - {2'b00, mag_a_q}) : {2'b00, mag_a_q};
    b_tc    = sign_b_q ? (17'd0 - {2'b00, mag_b_q}) : {2'b00, mag_b_q};
    sum_tc  = (opcode_q == OP_SUB) ? (a_tc - b_tc) : (a_tc + b_tc);
    sum_abs = sum_tc[16] ? (17'd0 - sum_tc) : sum_tc;
    if (opcode_q == OP_MUL) begin
      res_wide = mult_product;
      res_sign = sign_a_q ^ sign_b_q;
    end else begin
      res_wide = {13'd0, sum_abs};
      res_sign = sum_tc[16];
    end
  end

`ifdef GENCON_SATURATE_EN
  assign res_mag = (|res_wide[29:15]) ? MAX_MAG : res_wide[14:0];
`else
  logic unused_res_hi;
  assign unused_res_hi = ^res_wide[29:15];
  assign res_mag       = res_wide[14:0];
`endif

  assign result_sm = to_sm(res_sign, res_mag);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    next_state = current_state;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    opcode_d   = opcode_q;
    display_d  = display_q;
    complete_d = 1'b0;
    key_read_d = 1'b0;

    case (current_state)
      ENTER_A, ENTER_B: begin
        // Priority digit > operator > equal; a lower event in the same cycle is dropped.
        if (digit_evt) begin
          if (digit_ok) begin
            if (is_b) mag_b_d = digit_acc[14:0];
            else      mag_a_d = digit_acc[14:0];
            key_read_d = 1'b1;
            display_d  = to_sm(act_sign, digit_acc[14:0]);
          end
        end else if (op_evt) begin
          if (operator_input == OP_NEG) begin
            if (is_b) sign_b_d = ~sign_b_q;
            else      sign_a_d = ~sign_a_q;
            display_d = to_sm(~act_sign, act_mag);
          end else if (!is_b && is_arith_op(operator_input)) begin
            opcode_d   = operator_input;
            next_state = ENTER_B;
            display_d  = to_sm(sign_b_q, mag_b_q);
          end
        end else if (eq_evt && is_b) begin
          next_state = COMPUTE;
        end
      end
      COMPUTE: begin
        if ((opcode_q != OP_MUL) || mult_done) next_state = DONE;
      end
      DONE: begin
        complete_d = 1'b1;
        display_d  = result_sm;
        mag_a_d    = '0;
        mag_b_d    = '0;
        sign_a_d   = 1'b0;
        sign_b_d   = 1'b0;
        opcode_d   = '0;
        next_state = ENTER_A;
      end
      default: next_state = ENTER_A;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      current_state <= ENTER_A;
      read_prev_q   <= 1'b0;
      op_prev_q     <= 3'b000;
      equal_prev_q  <= 1'b0;
      mag_a_q       <= '0;
      mag_b_q       <= '0;
      sign_a_q      <= 1'b0;
      sign_b_q      <= 1'b0;
      opcode_q      <= '0;
      display_q     <= '0;
      complete_q    <= 1'b0;
      key_read_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same pre-edge values.
      current_state <= next_state;
      read_prev_q   <= read_input;
      op_prev_q     <= operator_input;
      equal_prev_q  <= equal_input;
      mag_a_q       <= mag_a_d;
      mag_b_q       <= mag_b_d;
      sign_a_q      <= sign_a_d;
      sign_b_q      <= sign_b_d;
      opcode_q      <= opcode_d;
      display_q     <= display_d;
      complete_q    <= complete_d;
      key_read_q    <= key_read_d;
    end
  end

  assign complete       = complete_q;
  assign display_output = display_q;
  assign key_read       = key_read_q;

endmodule

// File: tb/tb_gen_con.sv
// Directed self-checking bench for gen_con: entry, arithmetic, limits,
// event priority and reset abort, with hand-computed expected values.
module tb_gen_con;
  import gencon_pkg::*;

  logic        clk = 1'b0;
  logic        nRST;
  logic [3:0]  keypad_input;
  logic        read_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        complete;
  logic [15:0] display_output;
  logic        key_read;

  int vec_cnt = 0;
  int err_cnt = 0;

`ifdef GENCON_SATURATE_EN
  localparam logic [15:0] OVF_EXP = 16'h7FFF;
`else
  localparam logic [15:0] OVF_EXP = 16'h1C40;
`endif

  always #5 clk = ~clk;

  gen_con dut (
    .clk            (clk),
    .nRST           (nRST),
    .keypad_input   (keypad_input),
    .read_input     (read_input),
    .operator_input (operator_input),
    .equal_input    (equal_input),
    .complete       (complete),
    .display_output (display_output),
    .key_read       (key_read)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_digit(input logic [3:0] d, output logic kr);
    keypad_input = d;
    read_input   = 1'b1;
    step();
    kr = key_read;
    read_input = 1'b0;
    step();
  endtask

  task automatic press_op(input logic [2:0] code);
    operator_input = code;
    step();
    operator_input = 3'b000;
    step();
  endtask

  task automatic enter_number(input int n);
    int   digs[$];
    int   v;
    logic kr;
    v = n;
    do begin
      digs.push_front(v % 10);
      v = v / 10;
    end while (v > 0);
    foreach (digs[i]) press_digit(4'(digs[i]), kr);
  endtask

  // Presses equal, then reports latency to complete, pulse width and display values.
  task automatic wait_result(output int lat, output int width,
                             output logic [15:0] disp, output logic [15:0] hold);
    equal_input = 1'b1;
    step();
    equal_input = 1'b0;
    lat = -1; width = 0; disp = 'x; hold = 'x;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (complete === 1'b1) begin
        lat = c;
        break;
      end
    end
    if (lat > 0) begin
      disp = display_output;
      while (complete === 1'b1 && width < 5) begin
        width++;
        step();
      end
      repeat (2) step();
      hold = display_output;
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    keypad_input = '0; read_input = 1'b0; operator_input = '0; equal_input = 1'b0;
    repeat (2) step();
    vec_cnt++;
    if (dut.current_state !== 2'b00 || display_output !== 16'h0000 ||
        complete !== 1'b0 || key_read !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset: state=%b disp=%h complete=%b key_read=%b, want 00 0000 0 0",
               dut.current_state, display_output, complete, key_read);
    end
    @(negedge clk);
    nRST = 1'b1;
    step();
  endtask

  typedef struct {
    int          a;
    bit          na;
    logic [2:0]  op;
    int          b;
    bit          nb;
    int          lat;
    logic [15:0] exp;
  } calc_t;

  task automatic test_arith();
    calc_t tbl[12];
    int          lat, width;
    logic [15:0] disp, hold;
    tbl = '{
      '{4,     1'b0, OP_MUL, 3,     1'b0, 17, 16'h000C},
      '{2,     1'b1, OP_MUL, 5,     1'b0, 17, 16'h800A},
      '{3,     1'b1, OP_MUL, 6,     1'b1, 17, 16'h0012},
      '{32766, 1'b0, OP_ADD, 1,     1'b0, 2,  16'h7FFF},
      '{32766, 1'b1, OP_ADD, 1,     1'b1, 2,  16'hFFFF},
      '{181,   1'b0, OP_MUL, 181,   1'b0, 17, 16'h7FF9},
      '{200,   1'b0, OP_MUL, 200,   1'b0, 17, OVF_EXP},
      '{7,     1'b0, OP_SUB, 9,     1'b0, 2,  16'h8002},
      '{5,     1'b0, OP_SUB, 5,     1'b0, 2,  16'h0000},
      '{7,     1'b1, OP_MUL, 0,     1'b0, 17, 16'h0000},
      '{20000, 1'b0, OP_ADD, 20000, 1'b0, 2,  OVF_EXP},
      '{12,    1'b1, OP_SUB, 30,    1'b1, 2,  16'h0012}
    };
    foreach (tbl[i]) begin
      if (tbl[i].na) press_op(OP_NEG);
      enter_number(tbl[i].a);
      press_op(tbl[i].op);
      if (tbl[i].nb) press_op(OP_NEG);
      enter_number(tbl[i].b);
      wait_result(lat, width, disp, hold);
      vec_cnt++;
      if (lat !== tbl[i].lat || width !== 1 || disp !== tbl[i].exp || hold !== tbl[i].exp) begin
        err_cnt++;
        $display("FAIL arith[%0d] %s%0d op%b %s%0d: lat=%0d width=%0d disp=%h hold=%h, want lat=%0d width=1 disp=%h",
                 i, tbl[i].na ? "-" : "", tbl[i].a, tbl[i].op, tbl[i].nb ? "-" : "", tbl[i].b,
                 lat, width, disp, hold, tbl[i].lat, tbl[i].exp);
      end
    end
  endtask

  task automatic test_display_mirror();
    int          lat, width;
    logic [15:0] disp, hold;
    logic [15:0] seen[4];
    logic [15:0] want[4];
    want = '{16'h04D2, 16'h0000, 16'h0000, 16'h962E};
    enter_number(1234);      seen[0] = display_output;
    press_op(OP_ADD);        seen[1] = display_output;
    press_op(OP_NEG);        seen[2] = display_output;
    enter_number(5678);      seen[3] = display_output;
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (seen[i] !== want[i]) begin
        err_cnt++;
        $display("FAIL mirror step %0d: disp=%h, want %h", i, seen[i], want[i]);
      end
    end
    wait_result(lat, width, disp, hold);
    vec_cnt++;
    if (lat !== 2 || width !== 1 || disp !== 16'h915C) begin
      err_cnt++;
      $display("FAIL mirror result: lat=%0d width=%0d disp=%h, want lat=2 width=1 disp=915c",
               lat, width, disp);
    end
  endtask

  task automatic test_digit_limits();
    logic [3:0]  d[5];
    logic        want_kr[5];
    logic [15:0] want_disp[5];
    logic        kr;
    int          lat, width;
    logic [15:0] disp, hold;
    d         = '{4'd12, 4'd8, 4'd7, 4'd0, 4'd15};
    want_kr   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    want_disp = '{16'h0CCC, 16'h0CCC, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    enter_number(3276);
    for (int i = 0; i < 5; i++) begin
      press_digit(d[i], kr);
      vec_cnt++;
      if (kr !== want_kr[i] || display_output !== want_disp[i]) begin
        err_cnt++;
        $display("FAIL digit_limit key %0d: key_read=%b disp=%h, want key_read=%b disp=%h",
                 d[i], kr, display_output, want_kr[i], want_disp[i]);
      end
    end
    press_op(OP_ADD);
    enter_number(0);
    wait_result(lat, width, disp, hold);
    vec_cnt++;
    if (lat !== 2 || disp !== 16'h7FFF) begin
      err_cnt++;
      $display("FAIL digit_limit result: lat=%0d disp=%h, want lat=2 disp=7fff", lat, disp);
    end
  endtask

  task automatic test_priority();
    logic        kr;
    int          lat, width;
    logic [15:0] disp, hold;
    logic        saw_complete;
    // Digit and operator in the same cycle: operator dropped.
    keypad_input = 4'd3; read_input = 1'b1; operator_input = OP_ADD;
    step();
    vec_cnt++;
    if (dut.current_state !== 2'b00 || display_output !== 16'h0003 || key_read !== 1'b1) begin
      err_cnt++;
      $display("FAIL prio_digit_op: state=%b disp=%h key_read=%b, want 00 0003 1",
               dut.current_state, display_output, key_read);
    end
    read_input = 1'b0; operator_input = 3'b000;
    step();
    // Equal in ENTER_A is ignored.
    equal_input = 1'b1;
    step();
    equal_input = 1'b0;
    saw_complete = 1'b0;
    repeat (4) begin
      step();
      if (complete === 1'b1) saw_complete = 1'b1;
    end
    vec_cnt++;
    if (dut.current_state !== 2'b00 || saw_complete !== 1'b0) begin
      err_cnt++;
      $display("FAIL equal_in_enter_a: state=%b complete_seen=%b, want 00 0",
               dut.current_state, saw_complete);
    end
    press_op(OP_ADD);
    vec_cnt++;
    if (dut.current_state !== 2'b11) begin
      err_cnt++;
      $display("FAIL op_to_enter_b: state=%b, want 11", dut.current_state);
    end
    // Second arithmetic op ignored; operator beats equal in the same cycle.
    press_op(OP_MUL);
    operator_input = OP_NEG; equal_input = 1'b1;
    step();
    operator_input = 3'b000; equal_input = 1'b0;
    step();
    vec_cnt++;
    if (dut.current_state !== 2'b11) begin
      err_cnt++;
      $display("FAIL prio_op_equal: state=%b, want 11", dut.current_state);
    end
    press_digit(4'd4, kr);
    vec_cnt++;
    if (kr !== 1'b1 || display_output !== 16'h8004) begin
      err_cnt++;
      $display("FAIL neg_b_entry: key_read=%b disp=%h, want 1 8004", kr, display_output);
    end
    wait_result(lat, width, disp, hold);
    vec_cnt++;
    if (lat !== 2 || width !== 1 || disp !== 16'h8001) begin
      err_cnt++;
      $display("FAIL first_op_stands: lat=%0d width=%0d disp=%h, want lat=2 width=1 disp=8001",
               lat, width, disp);
    end
  endtask

  task automatic test_reset_mid_mult();
    logic saw_complete;
    enter_number(4);
    press_op(OP_MUL);
    enter_number(3);
    equal_input = 1'b1;
    step();
    equal_input = 1'b0;
    repeat (5) step();
    #2;
    nRST = 1'b0;
    #1;
    vec_cnt++;
    if (dut.current_state !== 2'b00 || display_output !== 16'h0000 || complete !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid_mult: state=%b disp=%h complete=%b, want 00 0000 0",
               dut.current_state, display_output, complete);
    end
    @(negedge clk);
    nRST = 1'b1;
    saw_complete = 1'b0;
    repeat (25) begin
      step();
      if (complete === 1'b1) saw_complete = 1'b1;
    end
    vec_cnt++;
    if (saw_complete !== 1'b0 || display_output !== 16'h0000) begin
      err_cnt++;
      $display("FAIL abort_no_complete: complete_seen=%b disp=%h, want 0 0000",
               saw_complete, display_output);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_display_mirror();
    test_reset();
    test_digit_limits();
    test_priority();
    test_reset_mid_mult();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
